bus_slave_arbiter: RTL
======================

# bus_slave_arbiter

Per-slave arbiter for the Avalon-MM bus crossbar. Each slave port gets one instance. The instance decodes which masters address its slave, grants one requester at a time using round-robin priority, and muxes that master's command onto the slave port. It then routes the slave's ReadData and WaitRequest back to the granted master only. A watchdog aborts transactions that a slave stalls indefinitely, so one hung slave cannot lock up the whole crossbar.

## Interface
- NUM_MASTERS, 2, number of master ports (2–8).
- SEL_NUM_BITS, 1, number of upper word-address bits decoded (1–30).
- SEL_VAL, 0, value those upper bits must equal for this slave (30 bits, right-aligned).
- TIMEOUT_CYCLES, 256, maximum stall cycles per transaction; 0 disables the watchdog.
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_AVIn_Addr  in  30*NUM_MASTERS  master word addresses, master m at bits [30m+29:30m].
- i_AVIn_ByteEn  in  4*NUM_MASTERS  master byte enables.
- i_AVIn_Read  in  NUM_MASTERS  master read strobes.
- i_AVIn_Write  in  NUM_MASTERS  master write strobes.
- i_AVIn_WriteData  in  32*NUM_MASTERS  master write data.
- o_AVIn_ReadData  out  32*NUM_MASTERS  read data returned to each master.
- o_AVIn_WaitRequest  out  NUM_MASTERS  per-master wait request; low only on that master's completion cycle.
- o_AVIn_Sel  out  NUM_MASTERS  combinational decode: master m addresses this slave. The crossbar uses it to pick which arbiter's WaitRequest/ReadData to return to m.
- o_AVOut_Addr  out  30  slave address (full 30 bits passed through).
- o_AVOut_ByteEn  out  4  slave byte enables.
- o_AVOut_Read  out  1  slave read strobe.
- o_AVOut_Write  out  1  slave write strobe.
- o_AVOut_WriteData  out  32  slave write data.
- i_AVOut_ReadData  in  32  slave read data.
- i_AVOut_WaitRequest  in  1  slave wait request.
- o_Grant  out  NUM_MASTERS  one-hot registered grant; all zero when idle.
- o_Timeout  out  1  one-cycle pulse when the watchdog aborts a transaction.

## Operation
- **Request decode.** Master m requests when all of these hold:
  - (Read[m] | Write[m]) = 1;
  - Addr[m][29:30-SEL_NUM_BITS] == SEL_VAL[SEL_NUM_BITS-1:0];
  - o_AVIn_Sel[m] = 1 (the address-decode term alone).
- **State machine, IDLE / BUSY.**
- **IDLE.**
  - If any request is present, pick the first requester searching from pointer P upward, wrapping modulo NUM_MASTERS.
  - Register the one-hot grant to that master, go to BUSY, and clear the watchdog counter.
- **BUSY, slave command.** The slave outputs carry the granted master's Addr, ByteEn, Read, Write and WriteData. Read and Write are forwarded unchanged (both high is a master protocol error and is not filtered).
- **BUSY, completion.** When i_AVOut_WaitRequest = 0:
  - o_AVIn_WaitRequest[g] = 0 and o_AVIn_ReadData[g] = i_AVOut_ReadData, both combinational in the same cycle;
  - next state IDLE, grant cleared, P = (g+1) mod NUM_MASTERS.
- **BUSY, stall.** While i_AVOut_WaitRequest = 1, the watchdog counter increments, saturating at TIMEOUT_CYCLES.
- **Timeout.** If the counter equals TIMEOUT_CYCLES and the slave still waits, in that cycle:
  - o_AVIn_WaitRequest[g] = 0;
  - o_AVIn_ReadData[g] = 32'hFFFFFFFF;
  - o_Timeout = 1;
  - next state IDLE, P advances as for a completion.
- **Simultaneous completion and timeout.** Normal completion wins: real ReadData is returned and o_Timeout stays 0.
- **Withdrawal.** If the granted master drops Read and Write while in BUSY (protocol violation), go to IDLE next cycle with no completion and P unchanged.
- **Ungranted masters.** A non-granted master sees WaitRequest = 1 and ReadData = 0.
- **Idle outputs.** When not in BUSY, all slave outputs are driven 0.

## Timing
- **Reset values.** State IDLE, P = 0, o_Grant = 0, counter = 0, every o_AVIn_WaitRequest bit = 1, every o_AVIn_ReadData = 0, all o_AVOut_* = 0, o_Timeout = 0.
- **Reset in BUSY.** The slave strobes drop in the next cycle. The master does not complete; it re-requests after reset.
- **Arbitration latency.** A request in cycle t drives the slave command in cycle t+1. Completion comes no earlier than t+1, so the minimum transaction is 2 cycles.
- **Back-to-back transactions.** A master gets them at best one every 2 cycles: after completion there is one IDLE cycle for re-arbitration.
- **Masters** must hold all signals stable while their WaitRequest is 1.
- **o_Grant** changes only on clock edges.
- **Watchdog.** An abort occurs on the cycle in which TIMEOUT_CYCLES stall cycles have already elapsed: the cycle t+1+TIMEOUT_CYCLES for a grant issued at t+1.

## Test plan
1. **Single read.** Reset, then master 0 reads Addr=0 with SEL_VAL=0 and the slave returns 32'h12345678 with WaitRequest=0. Required: slave Read=1 in cycle t+1; master 0 sees WaitRequest=0 and ReadData=32'h12345678 in t+1; P=1 afterwards.
2. **Round-robin.** Masters 0 and 1 request continuously and the slave has zero wait. Required: grants alternate 0,1,0,1; each master completes once every 4 cycles.
3. **Address decode.** Master 1 writes Addr=30'h20000000 with SEL_NUM_BITS=1, SEL_VAL=0. Required: o_AVIn_Sel[1]=0, no grant, slave outputs stay 0.
4. **Stalled write.** Master 0 writes ByteEn=4'b0011, WriteData=32'hA5A5A5A5 while the slave holds WaitRequest=1 for 3 cycles. Required: slave outputs stable for 4 cycles; completion occurs on the 4th BUSY cycle.
5. **Watchdog.** TIMEOUT_CYCLES=4 and the slave never releases. Required: on BUSY cycle 5, master WaitRequest=0, ReadData=32'hFFFFFFFF and o_Timeout=1 for exactly one cycle; the slave released on that same cycle gives normal completion with no Timeout.
6. **Reset mid-transaction.** Assert i_Reset in BUSY. Required: the next cycle shows all reset values, and o_AVOut_Read=0.

Source files
------------

// File: rtl/bus_slave_arbiter_if.sv
// Avalon-MM bundle between the masters, one per-slave arbiter and its slave port.
// The arbiter sits on the slave modport; the master modport is the crossbar/master view.
interface bus_slave_arbiter_if #(
   parameter int NUM_MASTERS = 2
);
   logic [30*NUM_MASTERS-1:0] i_AVIn_Addr;
   logic [4*NUM_MASTERS-1:0]  i_AVIn_ByteEn;
   logic [NUM_MASTERS-1:0]    i_AVIn_Read;
   logic [NUM_MASTERS-1:0]    i_AVIn_Write;
   logic [32*NUM_MASTERS-1:0] i_AVIn_WriteData;
   logic [32*NUM_MASTERS-1:0] o_AVIn_ReadData;
   logic [NUM_MASTERS-1:0]    o_AVIn_WaitRequest;
   logic [NUM_MASTERS-1:0]    o_AVIn_Sel;
   logic [29:0]               o_AVOut_Addr;
   logic [3:0]                o_AVOut_ByteEn;
   logic                      o_AVOut_Read;
   logic                      o_AVOut_Write;
   logic [31:0]               o_AVOut_WriteData;
   logic [31:0]               i_AVOut_ReadData;
   logic                      i_AVOut_WaitRequest;
   logic [NUM_MASTERS-1:0]    o_Grant;
   logic                      o_Timeout;

   modport slave (
      input  i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write, i_AVIn_WriteData,
      input  i_AVOut_ReadData, i_AVOut_WaitRequest,
      output o_AVIn_ReadData, o_AVIn_WaitRequest, o_AVIn_Sel,
      output o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData,
      output o_Grant, o_Timeout
   );

   modport master (
      output i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write, i_AVIn_WriteData,
      output i_AVOut_ReadData, i_AVOut_WaitRequest,
      input  o_AVIn_ReadData, o_AVIn_WaitRequest, o_AVIn_Sel,
      input  o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData,
      input  o_Grant, o_Timeout
   );
endinterface

// File: rtl/bus_slave_arbiter.sv
// Per-slave round-robin arbiter: decodes masters addressing this slave, grants one at a
// time, muxes its command to the slave and returns completion; a watchdog aborts stalls.
module bus_slave_arbiter #(
   parameter int          NUM_MASTERS    = 2,
   parameter int          SEL_NUM_BITS   = 1,
   parameter logic [29:0] SEL_VAL        = '0,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input logic                i_Clk,
   input logic                i_Reset,
   bus_slave_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                 state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [IDX_W-1:0]       gidx_q;
   logic [IDX_W-1:0]       ptr_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [NUM_MASTERS-1:0] sel;
   logic [NUM_MASTERS-1:0] req;
   logic                   found;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       cand_idx;
   int                     cand;
   logic                   busy;
   logic                   g_active;
   logic                   slave_done;
   logic                   wd_abort;
   logic [IDX_W-1:0]       ptr_d;

   always_comb begin
      sel = '0;
      req = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         sel[m] = (bus.i_AVIn_Addr[30*m+29 -: SEL_NUM_BITS] == SEL_VAL[SEL_NUM_BITS-1:0]);
         req[m] = sel[m] & (bus.i_AVIn_Read[m] | bus.i_AVIn_Write[m]);
      end
   end

   assign bus.o_AVIn_Sel = sel;

   // First requester at or above the round-robin pointer, wrapping.
   always_comb begin
      // NOTE: every variable gets a default first so no path through the block infers a latch.
      found    = 1'b0;
      win_idx  = ptr_q;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found   = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   assign busy       = (state_q == BUSY);
   assign g_active   = bus.i_AVIn_Read[gidx_q] | bus.i_AVIn_Write[gidx_q];
   assign slave_done = busy & g_active & ~bus.i_AVOut_WaitRequest;
   assign wd_abort   = (TIMEOUT_CYCLES != 0) && busy && g_active &&
                       bus.i_AVOut_WaitRequest && (cnt_q == CNT_MAX);
   assign ptr_d      = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

   always_comb begin
      bus.o_AVOut_Addr       = '0;
      bus.o_AVOut_ByteEn     = '0;
      bus.o_AVOut_Read       = 1'b0;
      bus.o_AVOut_Write      = 1'b0;
      bus.o_AVOut_WriteData  = '0;
      bus.o_AVIn_WaitRequest = '1;
      bus.o_AVIn_ReadData    = '0;
      if (busy) begin
         bus.o_AVOut_Addr      = bus.i_AVIn_Addr[30*gidx_q +: 30];
         bus.o_AVOut_ByteEn    = bus.i_AVIn_ByteEn[4*gidx_q +: 4];
         bus.o_AVOut_Read      = bus.i_AVIn_Read[gidx_q];
         bus.o_AVOut_Write     = bus.i_AVIn_Write[gidx_q];
         bus.o_AVOut_WriteData = bus.i_AVIn_WriteData[32*gidx_q +: 32];
      end
      if (slave_done) begin
         bus.o_AVIn_WaitRequest[gidx_q]         = 1'b0;
         bus.o_AVIn_ReadData[32*gidx_q +: 32]   = bus.i_AVOut_ReadData;
      end else if (wd_abort) begin
         bus.o_AVIn_WaitRequest[gidx_q]         = 1'b0;
         bus.o_AVIn_ReadData[32*gidx_q +: 32]   = 32'hFFFF_FFFF;
      end
   end

   assign bus.o_Grant   = grant_q;
   assign bus.o_Timeout = wd_abort;

   // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q <= BUSY;
                  grant_q <= NUM_MASTERS'(1) << win_idx;
                  gidx_q  <= win_idx;
                  cnt_q   <= '0;
               end
            end
            BUSY: begin
               // A withdrawn master leaves without completing, so the pointer stays put.
               if (!g_active) begin
                  state_q <= IDLE;
                  grant_q <= '0;
               end else if (slave_done || wd_abort) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
